// File: rtl/retire_monitor_if.sv
// Writeback-observation and counter-readout bundle for retire_monitor.
// The master side drives writeback/control inputs; the slave side is the monitor.
interface retire_monitor_if;
   logic        valid_w;
   logic [31:0] inst_w;
   logic [31:0] pc_w;
   logic [4:0]  en_clt;
   logic [4:0]  rst_clt;
   logic [1:0]  rd_addr;
   logic [31:0] rd_data;
   logic        halted;
   logic [31:0] halt_pc;
   logic [1:0]  state;

   modport master (
      output valid_w, inst_w, pc_w, en_clt, rst_clt, rd_addr,
      input  rd_data, halted, halt_pc, state
   );

   modport slave (
      input  valid_w, inst_w, pc_w, en_clt, rst_clt, rd_addr,
      output rd_data, halted, halt_pc, state
   );
endinterface

// File: rtl/retire_monitor.sv
// Pipeline retire monitor: saturating cycle/retire counters, halt capture, registered readout.
// Define RETIRE_MONITOR_STALL_CNT_EN to build in the stall and flush counters.
//
// state  | meaning
// IDLE   | out of reset, waiting for the first real instruction in writeback
// RUN    | counting; a retiring 32'h00000033 moves to HALTED
// HALTED | halt retired, counters frozen until rst_pc
module retire_monitor (
   input logic               clk,
   input logic               rst_pc,
   retire_monitor_if.slave   mon
);
   localparam logic [31:0] HALT_INST = 32'h0000_0033;
   localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;
   logic [31:0] rd_data_q;
   logic        halted_q;
   logic [31:0] halt_pc_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CNT_MAX) ? v : v + 32'd1;
   endfunction

`ifdef RETIRE_MONITOR_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   always_ff @(posedge clk) begin
      if (rst_pc) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (state_q == RUN) begin
         if (mon.en_clt != 5'b11111)
            stall_cnt <= sat_inc(stall_cnt);
         if (mon.rst_clt != 5'b00000)
            flush_cnt <= sat_inc(flush_cnt);
      end
   end
`else
   logic unused_stage_ctl;
   assign unused_stage_ctl = ^{mon.en_clt, mon.rst_clt};
`endif

   always_ff @(posedge clk) begin
      if (rst_pc) begin
         state_q    <= IDLE;
         cycle_cnt  <= '0;
         retire_cnt <= '0;
         rd_data_q  <= '0;
         halted_q   <= 1'b0;
         halt_pc_q  <= '0;
      end else begin
         // Readout samples counters before this edge's increments land.
         case (mon.rd_addr)
            2'd0:    rd_data_q <= cycle_cnt;
            2'd1:    rd_data_q <= retire_cnt;
`ifdef RETIRE_MONITOR_STALL_CNT_EN
            2'd2:    rd_data_q <= stall_cnt;
            default: rd_data_q <= flush_cnt;
`else
            default: rd_data_q <= '0;
`endif
         endcase

         case (state_q)
            IDLE: begin
               if (mon.valid_w) begin
                  state_q    <= RUN;
                  retire_cnt <= sat_inc(retire_cnt);
               end
            end
            RUN: begin
               cycle_cnt <= sat_inc(cycle_cnt);
               if (mon.valid_w) begin
                  retire_cnt <= sat_inc(retire_cnt);
                  if (mon.inst_w == HALT_INST) begin
                     state_q   <= HALTED;
                     halted_q  <= 1'b1;
                     halt_pc_q <= mon.pc_w;
                  end
               end
            end
            HALTED: ;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mon.rd_data = rd_data_q;
   assign mon.halted  = halted_q;
   assign mon.halt_pc = halt_pc_q;
   assign mon.state   = state_q;
endmodule
